// File: rtl/baby_store_scan_if.sv
// CPU, front-panel and display-scan signals of the SSEM main store.
// The master side is the control unit / display block; the slave is the store.
interface baby_store_scan_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
);
    logic              clr;
    logic [AWIDTH-1:0] a;
    logic [DWIDTH-1:0] d;
    logic              we;
    logic              re;
    logic [DWIDTH-1:0] q;
    logic              q_valid;
    logic              busy;
    logic              scan_en;
    logic [AWIDTH-1:0] scan_addr;
    logic [DWIDTH-1:0] scan_data;
    logic              scan_valid;
    logic              scan_frame;

    modport master (
        output clr, a, d, we, re, scan_en,
        input  q, q_valid, busy,
        input  scan_addr, scan_data, scan_valid, scan_frame
    );

    modport slave (
        input  clr, a, d, we, re, scan_en,
        output q, q_valid, busy,
        output scan_addr, scan_data, scan_valid, scan_frame
    );
endinterface

// File: rtl/baby_store_scan.sv
// SSEM main store: one write port, a CPU read port, a paced display scan
// port and a serial clear sequencer started by reset or the panel clear.
module baby_store_scan #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int LINES    = 32,
    parameter int SCAN_DIV = 4
) (
    input logic              clk,
    input logic              mrst,
    baby_store_scan_if.slave bus
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [AWIDTH:0] LAST = (AWIDTH+1)'(LINES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DWIDTH-1:0] q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [AWIDTH-1:0] ptr_q, ptr_d;
    logic [AWIDTH-1:0] scan_addr_q, scan_addr_d;
    logic [DWIDTH-1:0] scan_data_q, scan_data_d;
    logic              scan_valid_q, scan_valid_d;
    logic              scan_frame_q, scan_frame_d;

    logic [DWIDTH-1:0] mem_q [LINES];

    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              idle;
    logic              a_ok;
    logic              enter_clr;
    logic [DWIDTH-1:0] cpu_rd;
    logic [DWIDTH-1:0] scan_rd;

    always_comb begin
        idle      = (state_q == S_IDLE);
        a_ok      = ({1'b0, bus.a} <= LAST);
        enter_clr = idle & bus.clr;
        cpu_rd    = a_ok ? mem_q[bus.a] : '0;
        scan_rd   = mem_q[ptr_q];
    end

    // Clear sequencer and the single write port it shares with the CPU.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_en     = 1'b0;
        wr_addr   = bus.a;
        wr_data   = bus.d;
        unique case (state_q)
            S_IDLE: begin
                wr_en = bus.we & a_ok;
                if (bus.clr) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if ({1'b0, clr_cnt_q} == LAST) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        if (mrst) begin
            wr_en = 1'b0;
        end
    end

    always_comb begin
        q_d       = q_q;
        q_valid_d = 1'b0;
        if (idle && bus.re && !bus.we) begin
            q_d       = cpu_rd;
            q_valid_d = 1'b1;
        end
    end

    always_comb begin
        div_d        = div_q;
        ptr_d        = ptr_q;
        scan_addr_d  = scan_addr_q;
        scan_data_d  = scan_data_q;
        scan_valid_d = 1'b0;
        scan_frame_d = 1'b0;
        if (idle && bus.scan_en) begin
            if (div_q == DIV_LAST) begin
                div_d        = '0;
                scan_addr_d  = ptr_q;
                scan_data_d  = scan_rd;
                scan_valid_d = 1'b1;
                scan_frame_d = (ptr_q == '0);
                ptr_d = ({1'b0, ptr_q} == LAST) ? '0 : ptr_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        // A new clear always restarts the frame at line 0.
        if (enter_clr) begin
            div_d = '0;
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mrst) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= '0;
            q_q          <= '0;
            q_valid_q    <= 1'b0;
            div_q        <= '0;
            ptr_q        <= '0;
            scan_addr_q  <= '0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
            scan_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            q_q          <= q_d;
            q_valid_q    <= q_valid_d;
            div_q        <= div_d;
            ptr_q        <= ptr_d;
            scan_addr_q  <= scan_addr_d;
            scan_data_q  <= scan_data_d;
            scan_valid_q <= scan_valid_d;
            scan_frame_q <= scan_frame_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign bus.q          = q_q;
    assign bus.q_valid    = q_valid_q;
    assign bus.busy       = (state_q == S_CLEAR);
    assign bus.scan_addr  = scan_addr_q;
    assign bus.scan_data  = scan_data_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.scan_frame = scan_frame_q;
endmodule

// File: tb/tb_baby_store_scan.sv
// Scoreboard bench: two stores (32 lines / div 4, 24 lines / div 1) share
// one random stimulus stream and are checked against an abstract model.
module tb_baby_store_scan;
    typedef struct packed {
        logic        busy;
        logic        qv;
        logic [31:0] q;
        logic        sv;
        logic [4:0]  sa;
        logic [31:0] sd;
        logic        sf;
    } rec_t;

    logic        clk = 1'b0;
    logic        mrst, clr, we, re, scan_en;
    logic [4:0]  a;
    logic [31:0] d;

    int checks = 0;
    int errors = 0;

    rec_t q0[$];
    rec_t q1[$];

    int          ln [2] = '{32, 24};
    int          dv [2] = '{4, 1};
    logic [31:0] m_mem [2][32];
    bit          m_busy [2];
    int          m_left [2];
    int          m_ptr [2];
    int          m_div [2];
    int          m_sa [2];
    logic [31:0] m_q [2];
    logic [31:0] m_sd [2];

    baby_store_scan_if #(.DWIDTH(32), .AWIDTH(5)) if0 ();
    baby_store_scan_if #(.DWIDTH(32), .AWIDTH(5)) if1 ();

    assign if0.clr = clr;  assign if1.clr = clr;
    assign if0.a = a;      assign if1.a = a;
    assign if0.d = d;      assign if1.d = d;
    assign if0.we = we;    assign if1.we = we;
    assign if0.re = re;    assign if1.re = re;
    assign if0.scan_en = scan_en;
    assign if1.scan_en = scan_en;

    baby_store_scan #(.DWIDTH(32), .AWIDTH(5), .LINES(32), .SCAN_DIV(4))
        dut0 (.clk(clk), .mrst(mrst), .bus(if0));
    baby_store_scan #(.DWIDTH(32), .AWIDTH(5), .LINES(24), .SCAN_DIV(1))
        dut1 (.clk(clk), .mrst(mrst), .bus(if1));

    always #5 clk = ~clk;

    // A clear blocks every access until it ends, so the model wipes the
    // whole store at the moment the clear starts.
    function automatic void wipe(int k);
        for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
        m_busy[k] = 1'b1;
        m_left[k] = ln[k];
        m_ptr[k]  = 0;
        m_div[k]  = 0;
    endfunction

    function automatic rec_t model_step(int k);
        rec_t r;
        r.qv = 1'b0;
        r.sv = 1'b0;
        r.sf = 1'b0;
        if (mrst) begin
            wipe(k);
            m_q[k]  = '0;
            m_sa[k] = 0;
            m_sd[k] = '0;
        end else if (m_busy[k]) begin
            m_left[k]--;
            if (m_left[k] == 0) m_busy[k] = 1'b0;
        end else begin
            if (scan_en) begin
                m_div[k]++;
                if (m_div[k] == dv[k]) begin
                    m_div[k] = 0;
                    r.sv     = 1'b1;
                    r.sf     = (m_ptr[k] == 0);
                    m_sa[k]  = m_ptr[k];
                    m_sd[k]  = m_mem[k][m_ptr[k]];
                    m_ptr[k] = (m_ptr[k] + 1) % ln[k];
                end
            end
            if (re && !we) begin
                r.qv   = 1'b1;
                m_q[k] = (int'(a) < ln[k]) ? m_mem[k][a] : 32'h0;
            end
            if (we && int'(a) < ln[k]) m_mem[k][a] = d;
            if (clr) wipe(k);
        end
        r.busy = m_busy[k];
        r.q    = m_q[k];
        r.sa   = 5'(m_sa[k]);
        r.sd   = m_sd[k];
        return r;
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h want %h",
                     name, k, $time, act, exp);
        end
    endtask

    task automatic cyc();
        q0.push_back(model_step(0));
        q1.push_back(model_step(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("busy", 0, if0.busy, e.busy);
                chk("q_valid", 0, if0.q_valid, e.qv);
                chk("q", 0, if0.q, e.q);
                chk("scan_valid", 0, if0.scan_valid, e.sv);
                chk("scan_addr", 0, if0.scan_addr, e.sa);
                chk("scan_data", 0, if0.scan_data, e.sd);
                chk("scan_frame", 0, if0.scan_frame, e.sf);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("busy", 1, if1.busy, e.busy);
                chk("q_valid", 1, if1.q_valid, e.qv);
                chk("q", 1, if1.q, e.q);
                chk("scan_valid", 1, if1.scan_valid, e.sv);
                chk("scan_addr", 1, if1.scan_addr, e.sa);
                chk("scan_data", 1, if1.scan_data, e.sd);
                chk("scan_frame", 1, if1.scan_frame, e.sf);
            end
        end
    end

    initial begin
        int  n;
        bit  hit;
        mrst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        scan_en = 1'b0; a = '0; d = '0;
        repeat (3) cyc();
        mrst = 1'b0;
        n = 0;
        while (if0.busy && n < 100) begin
            n++;
            cyc();
        end
        chk("busy_len", 0, n, 32);

        for (int i = 0; i < 32; i++) begin
            re = 1'b1; a = 5'(i); cyc();
        end
        re = 1'b0;

        we = 1'b1; a = 5'd7; d = 32'hDEADBEEF; cyc();
        we = 1'b0; re = 1'b1; cyc();
        we = 1'b1; d = 32'h12345678; cyc();
        we = 1'b0; cyc();
        re = 1'b0;

        we = 1'b1; a = 5'd30; d = 32'hCAFEF00D; cyc();
        we = 1'b0; re = 1'b1; cyc();
        for (int i = 0; i < 24; i++) begin
            a = 5'(i); cyc();
        end
        re = 1'b0;

        clr = 1'b1; cyc();
        clr = 1'b0; we = 1'b1; a = 5'd3; d = 32'h55555555; cyc();
        we = 1'b0;
        repeat (35) cyc();
        re = 1'b1; a = 5'd3; cyc();
        re = 1'b0;

        clr = 1'b1; cyc();
        clr = 1'b0;
        repeat (10) cyc();
        mrst = 1'b1; cyc();
        mrst = 1'b0;
        repeat (35) cyc();

        for (int i = 0; i < 32; i++) begin
            we = 1'b1; a = 5'(i); d = 32'(i + 1); cyc();
        end
        we = 1'b0;

        scan_en = 1'b1;
        hit = 1'b0;
        for (int t = 0; t < 300; t++) begin
            we = 1'b0;
            if (!hit && m_div[0] == dv[0] - 1 && m_ptr[0] == 5) begin
                hit = 1'b1; we = 1'b1; a = 5'd5; d = 32'hA5A5A5A5;
            end
            cyc();
        end
        we = 1'b0;
        scan_en = 1'b0;
        repeat (10) cyc();
        scan_en = 1'b1;
        repeat (20) cyc();

        repeat (1500) begin
            mrst    = ($urandom % 300) == 0;
            clr     = ($urandom % 80) == 0;
            a       = 5'($urandom % 32);
            d       = $urandom;
            we      = ($urandom % 4) == 0;
            re      = ($urandom % 3) == 0;
            scan_en = ($urandom % 8) != 0;
            cyc();
        end
        mrst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
        repeat (3) cyc();
        repeat (2) @(posedge clk);
        chk("drain", 0, q0.size(), 0);
        chk("drain", 1, q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
